// File: rtl/tone_scheduler.sv
// Tone and melody scheduler for a square-wave sound generator.
// A millisecond timebase derived from ticks_per_milli paces either a single
// requested tone or one of two built-in melodies. The output freq is the pitch
// to play, with 0 meaning silence.
module tone_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    input  logic        tone_req,
    input  logic [9:0]  tone_freq,
    input  logic [9:0]  tone_ms,
    input  logic        melody_start,
    input  logic [1:0]  melody_sel,
    input  logic        stop,
    output logic [9:0]  freq,
    output logic        busy,
    output logic        ack,
    output logic        done,
    output logic [2:0]  note_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TONE   = 2'd1,
        MELODY = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [15:0] tick_cnt, tick_nx, tick_last;
    logic        ms_tick;
    logic [9:0]  ms_left, ms_nx;
    logic [9:0]  freq_nx;
    logic [2:0]  idx_nx;
    logic        ack_nx, done_nx;
    logic        gameover, gameover_nx;
    logic        mel_ok;

    // Pitch of a melody note; notes past the end are silent.
    function automatic logic [9:0] note_freq(input logic over, input logic [2:0] idx);
        logic [9:0] f;
        f = 10'd0;
        if (over) begin
            case (idx)
                3'd0:    f = 10'd622;
                3'd1:    f = 10'd587;
                3'd2:    f = 10'd554;
                3'd3:    f = 10'd523;
                3'd4:    f = 10'd523;
                default: f = 10'd0;
            endcase
        end else begin
            case (idx)
                3'd0:    f = 10'd330;
                3'd1:    f = 10'd392;
                3'd2:    f = 10'd659;
                3'd3:    f = 10'd523;
                3'd4:    f = 10'd587;
                3'd5:    f = 10'd784;
                default: f = 10'd0;
            endcase
        end
        return f;
    endfunction

    // Duration of a melody note in milliseconds.
    function automatic logic [9:0] note_ms(input logic over, input logic [2:0] idx);
        logic [9:0] d;
        if (over) d = (idx == 3'd4) ? 10'd1000 : 10'd300;
        else      d = 10'd150;
        return d;
    endfunction

    // Index of the final note of the selected melody.
    function automatic logic [2:0] last_idx(input logic over);
        return over ? 3'd4 : 3'd6;
    endfunction

    // A period of 0 behaves like 1 so the timebase never stalls. Using >= lets a
    // shrinking period take effect at the very next cycle.
    assign tick_last = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    assign ms_tick   = (tick_cnt >= tick_last);
    // Reserved selectors behave as if melody_start were absent.
    assign mel_ok    = melody_start && !melody_sel[1];
    assign busy      = (state != IDLE);

    // Next-state and output decode: stop beats melody_start beats tone_req.
    always_comb begin
        state_nx    = state;
        freq_nx     = freq;
        idx_nx      = note_idx;
        ms_nx       = ms_left;
        gameover_nx = gameover;
        ack_nx      = 1'b0;
        done_nx     = 1'b0;
        tick_nx     = ms_tick ? 16'd0 : tick_cnt + 16'd1;

        if (stop) begin
            if (state != IDLE) begin
                state_nx = IDLE;
                freq_nx  = 10'd0;
                idx_nx   = 3'd0;
                ms_nx    = 10'd0;
            end
        end else if (mel_ok) begin
            state_nx    = MELODY;
            gameover_nx = melody_sel[0];
            idx_nx      = 3'd0;
            freq_nx     = note_freq(melody_sel[0], 3'd0);
            ms_nx       = note_ms(melody_sel[0], 3'd0);
            ack_nx      = 1'b1;
            tick_nx     = 16'd0;
        end else if (tone_req && state == IDLE) begin
            ack_nx  = 1'b1;
            tick_nx = 16'd0;
            if (tone_ms == 10'd0) begin
                done_nx = 1'b1;
            end else begin
                state_nx = TONE;
                freq_nx  = tone_freq;
                ms_nx    = tone_ms;
            end
        end else if (state != IDLE && ms_tick) begin
            if (ms_left > 10'd1) begin
                ms_nx = ms_left - 10'd1;
            end else if (state == MELODY && note_idx != last_idx(gameover)) begin
                idx_nx  = note_idx + 3'd1;
                freq_nx = note_freq(gameover, note_idx + 3'd1);
                ms_nx   = note_ms(gameover, note_idx + 3'd1);
            end else begin
                state_nx = IDLE;
                freq_nx  = 10'd0;
                idx_nx   = 3'd0;
                ms_nx    = 10'd0;
                done_nx  = 1'b1;
            end
        end
    end

    // State, timebase and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= 16'd0;
            ms_left  <= 10'd0;
            freq     <= 10'd0;
            note_idx <= 3'd0;
            gameover <= 1'b0;
            ack      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_nx;
            ms_left  <= ms_nx;
            freq     <= freq_nx;
            note_idx <= idx_nx;
            gameover <= gameover_nx;
            ack      <= ack_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler: directed scenarios followed by random
// traffic, all compared against a note-queue reference model.
module tb_tone_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ticks_per_milli = 16'd4;
    logic        tone_req = 1'b0;
    logic [9:0]  tone_freq = 10'd0;
    logic [9:0]  tone_ms = 10'd0;
    logic        melody_start = 1'b0;
    logic [1:0]  melody_sel = 2'd0;
    logic        stop = 1'b0;
    logic [9:0]  freq;
    logic        busy;
    logic        ack;
    logic        done;
    logic [2:0]  note_idx;

    int n_assert = 0;
    int n_fail   = 0;

    tone_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .ticks_per_milli(ticks_per_milli),
        .tone_req       (tone_req),
        .tone_freq      (tone_freq),
        .tone_ms        (tone_ms),
        .melody_start   (melody_start),
        .melody_sel     (melody_sel),
        .stop           (stop),
        .freq           (freq),
        .busy           (busy),
        .ack            (ack),
        .done           (done),
        .note_idx       (note_idx)
    );

    always #5 clk = ~clk;

    // Reference model: playback is a queue of (pitch, ms) notes; the head is
    // what is sounding, m_ms is how many milliseconds of it remain.
    int succ_f[7] = '{330, 392, 659, 523, 587, 784, 0};
    int over_f[5] = '{622, 587, 554, 523, 523};
    int over_m[5] = '{300, 300, 300, 300, 1000};
    int qf[$];
    int qm[$];
    bit m_play = 0;
    bit m_mel  = 0;
    int m_tick = 0;
    int m_ms   = 0;
    int m_idx  = 0;
    int e_freq = 0;
    int e_idx  = 0;
    bit e_ack  = 0;
    bit e_done = 0;

    task automatic model_idle();
        m_play = 0;
        m_mel  = 0;
        m_idx  = 0;
        qf.delete();
        qm.delete();
    endtask

    task automatic model_step();
        int  period;
        bit  fire;
        e_ack  = 0;
        e_done = 0;
        if (rst) begin
            model_idle();
            m_tick = 0;
            m_ms   = 0;
        end else begin
            period = (ticks_per_milli == 0) ? 1 : int'(ticks_per_milli);
            fire   = (m_tick >= period - 1);
            m_tick = fire ? 0 : m_tick + 1;
            if (stop) begin
                if (m_play) model_idle();
            end else if (melody_start && melody_sel < 2) begin
                model_idle();
                if (melody_sel == 0) begin
                    for (int i = 0; i < 7; i++) begin qf.push_back(succ_f[i]); qm.push_back(150); end
                end else begin
                    for (int i = 0; i < 5; i++) begin qf.push_back(over_f[i]); qm.push_back(over_m[i]); end
                end
                m_play = 1;
                m_mel  = 1;
                m_ms   = qm[0];
                m_tick = 0;
                e_ack  = 1;
            end else if (tone_req && !m_play) begin
                m_tick = 0;
                e_ack  = 1;
                if (tone_ms == 0) begin
                    e_done = 1;
                end else begin
                    qf.push_back(int'(tone_freq));
                    qm.push_back(int'(tone_ms));
                    m_play = 1;
                    m_ms   = qm[0];
                end
            end else if (m_play && fire) begin
                m_ms--;
                if (m_ms == 0) begin
                    void'(qf.pop_front());
                    void'(qm.pop_front());
                    if (qf.size() == 0) begin
                        model_idle();
                        e_done = 1;
                    end else begin
                        m_idx++;
                        m_ms = qm[0];
                    end
                end
            end
        end
        e_freq = m_play ? qf[0] : 0;
        e_idx  = m_mel ? m_idx : 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the edge, compare #1 later, drop pulses.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("freq", {22'd0, freq}, e_freq);
        chk("busy", {31'd0, busy}, {31'd0, m_play});
        chk("ack", {31'd0, ack}, {31'd0, e_ack});
        chk("done", {31'd0, done}, {31'd0, e_done});
        chk("note_idx", {29'd0, note_idx}, e_idx);
        tone_req     = 1'b0;
        melody_start = 1'b0;
        stop         = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int cnt;

        // Reset state
        rst = 1'b1;
        run(2);
        chk("rst_freq", {22'd0, freq}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        run(3);

        // 4 ticks/ms, 262 Hz for 3 ms -> 12 cycles of tone
        ticks_per_milli = 16'd4;
        tone_req = 1'b1; tone_freq = 10'd262; tone_ms = 10'd3;
        cyc();
        chk("tone_ack", {31'd0, ack}, 1);
        cnt = 0;
        for (int i = 0; i < 20 && freq == 10'd262; i++) begin
            cnt++;
            cyc();
        end
        chk("tone_len", cnt, 12);
        chk("tone_done", {31'd0, done}, 1);
        run(3);

        // Zero-length tone: ack and done together, stays idle
        tone_req = 1'b1; tone_freq = 10'd440; tone_ms = 10'd0;
        cyc();
        chk("zero_ack", {31'd0, ack}, 1);
        chk("zero_done", {31'd0, done}, 1);
        chk("zero_busy", {31'd0, busy}, 0);
        run(2);

        // Success melody at 2 ticks/ms: 7 notes x 300 cycles
        ticks_per_milli = 16'd2;
        melody_start = 1'b1; melody_sel = 2'd0;
        cyc();
        chk("mel_first", {22'd0, freq}, 330);
        run(2099);
        chk("mel_pre_done", {31'd0, done}, 0);
        cyc();
        chk("mel_done", {31'd0, done}, 1);
        run(2);

        // Tone ignores tone_req; gameover melody preempts without done
        ticks_per_milli = 16'd1;
        tone_req = 1'b1; tone_freq = 10'd500; tone_ms = 10'd20;
        cyc();
        run(4);
        tone_req = 1'b1; tone_freq = 10'd100; tone_ms = 10'd2;
        cyc();
        chk("ign_ack", {31'd0, ack}, 0);
        run(2);
        melody_start = 1'b1; melody_sel = 2'd1;
        cyc();
        chk("pre_freq", {22'd0, freq}, 622);
        chk("pre_done", {31'd0, done}, 0);
        run(2205);

        // Stop during note 3 of the success melody
        melody_start = 1'b1; melody_sel = 2'd0;
        cyc();
        for (int i = 0; i < 1000 && note_idx != 3'd3; i++) cyc();
        chk("at_note3", {29'd0, note_idx}, 3);
        run(10);
        stop = 1'b1;
        cyc();
        chk("stop_freq", {22'd0, freq}, 0);
        chk("stop_busy", {31'd0, busy}, 0);
        run(3);

        // All three requests at once in idle: stop wins, nothing accepted
        stop = 1'b1; melody_start = 1'b1; melody_sel = 2'd0;
        tone_req = 1'b1; tone_ms = 10'd4;
        cyc();
        chk("all3_ack", {31'd0, ack}, 0);
        melody_start = 1'b1; melody_sel = 2'd3;
        cyc();
        chk("sel3_ack", {31'd0, ack}, 0);
        run(2);

        // Period 0 behaves as 1: 5 ms -> 5 cycles, then reset mid-tone
        ticks_per_milli = 16'd0;
        tone_req = 1'b1; tone_freq = 10'd77; tone_ms = 10'd5;
        cyc();
        run(6);
        tone_req = 1'b1; tone_freq = 10'd77; tone_ms = 10'd5;
        cyc();
        cyc();
        rst = 1'b1;
        tone_req = 1'b1;
        cyc();
        chk("rst_mid_freq", {22'd0, freq}, 0);
        chk("rst_mid_done", {31'd0, done}, 0);
        rst = 1'b0;
        run(8);

        // Longest duration, and a period change part-way through a tone
        ticks_per_milli = 16'd1;
        tone_req = 1'b1; tone_freq = 10'd999; tone_ms = 10'd1023;
        cyc();
        run(1022);
        chk("long_busy", {31'd0, busy}, 1);
        cyc();
        chk("long_done", {31'd0, done}, 1);
        ticks_per_milli = 16'd8;
        tone_req = 1'b1; tone_freq = 10'd300; tone_ms = 10'd3;
        cyc();
        run(6);
        ticks_per_milli = 16'd3;
        run(20);

        // Random traffic
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 999) < 3) ticks_per_milli = 16'($urandom_range(0, 5));
            rst          = ($urandom_range(0, 999) < 2);
            stop         = ($urandom_range(0, 199) < 1);
            melody_start = ($urandom_range(0, 199) < 1);
            melody_sel   = 2'($urandom_range(0, 3));
            tone_req     = ($urandom_range(0, 99) < 3);
            tone_freq    = 10'($urandom_range(1, 1023));
            tone_ms      = 10'($urandom_range(0, 12));
            if (melody_start && melody_sel[1]) tone_req = 1'b0;
            cyc();
        end
        rst = 1'b0;
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
